mc_arb_fsm: RTL and testbench
=============================

// Module: mc_arb_fsm
// PURPOSE
//  Multi-channel front-end arbiter/sequencer for the memory controller.
//  Arbitrates NUM_CH AXI frame sources, routes the granted frame to the read or write controller,
//  and schedules periodic refreshes with a postponement counter.
//  Sits between the AXI slave frame FIFOs and the read/write/refresh engines.
// PARAMETERS
//  NUM_CH      2   number of frame source channels (>=1)
//  FRAME_WIDTH 87  frame width in bits
//  CMD_BIT     84  frame bit selecting the command: 1=write, 0=read
//  CNT_WIDTH   28  width of the refresh timer and its config inputs
//  MAX_PEND_RF 4   maximum number of postponed refreshes held in rf_pend (>=1)
// PORTS
//  clk                    in   1                   clock
//  rstn                   in   1                   synchronous active-low reset
//  mc_en                  in   1                   controller enable
//  mc_rf_start_time_cfg   in   CNT_WIDTH           timer value at which a refresh is requested
//  mc_rf_period_time_cfg  in   CNT_WIDTH           timer terminal value (period = cfg+1 cycles)
//  ch_frame_data          in   NUM_CH*FRAME_WIDTH  per-channel frames; channel i at [i*FRAME_WIDTH +: FRAME_WIDTH]
//  ch_frame_valid         in   NUM_CH              per-channel frame valid
//  ch_frame_ready         out  NUM_CH              per-channel frame ready
//  axi_wframe_data        out  FRAME_WIDTH         frame to write controller
//  axi_wframe_valid       out  1                   frame valid to write controller
//  axi_wframe_ready       in   1                   ready from write controller
//  write_finish_i         in   1                   write burst complete (1-cycle pulse)
//  axi_rframe_data        out  FRAME_WIDTH         frame to read controller
//  axi_rframe_valid       out  1                   frame valid to read controller
//  axi_rframe_ready       in   1                   ready from read controller
//  read_finish_i          in   1                   read burst complete (1-cycle pulse)
//  refresh_start_o        out  1                   refresh engine start (1-cycle pulse)
//  refresh_finish_i       in   1                   refresh complete (1-cycle pulse)
//  grant_o                out  NUM_CH              one-hot grant of the current owner
//  curr_state_o           out  2                   FSM state: 0=IDLE, 1=READ, 2=WRITE, 3=REFRESH
//  rf_overflow_o          out  1                   sticky: refresh due while rf_pend==MAX_PEND_RF
// BEHAVIOUR
//  Reset values
//   - All registered state clears when rstn=0 at a clk edge: state=IDLE, grant=0, rr pointer=0,
//     rf_cnt=0, rf_pend=0, rf_overflow_o=0.
//   - All outputs are 0 while in reset.
//  Refresh timer
//   - mc_en=1: rf_cnt increments each cycle; on rf_cnt==period_cfg the next value is 0.
//   - mc_en=0: rf_cnt forced to 0. rf_pend is held.
//  Refresh request counter (rf_pend)
//   - rf_due = mc_en & (rf_cnt==start_cfg).
//   - rf_due increments rf_pend; refresh_finish_i in REFRESH decrements it.
//   - Both events in the same cycle leave rf_pend unchanged.
//   - rf_due at MAX_PEND_RF saturates rf_pend and sets rf_overflow_o; only reset clears it.
//  FSM transitions
//   - IDLE:
//      - Leaves IDLE only when mc_en=1; priority is rf_pend!=0 -> REFRESH.
//      - Otherwise, if any ch_frame_valid: the arbiter picks a channel and registers the one-hot
//        grant, then goes to WRITE if the chosen frame's CMD_BIT=1, else READ.
//      - Otherwise stays in IDLE.
//   - READ/WRITE: hold the state and grant until the matching *_finish_i, then go to REFRESH if
//     rf_pend!=0 (counting an rf_due in that same cycle), else IDLE.
//     - Grant clears on the exit.
//     - Unrelated finish pulses are ignored.
//   - REFRESH:
//      - refresh_start_o pulses for exactly the first cycle after entry.
//      - On refresh_finish_i go to IDLE.
//      - If rf_pend is still !=0, the next IDLE cycle re-enters REFRESH.
//   - mc_en falling mid-transaction does not abort; the current state runs to its finish pulse.
//  Datapath (combinational)
//   - axi_wframe_data = axi_rframe_data = frame of the granted channel (0 when no grant).
//   - axi_wframe_valid = (state==WRITE) & ch_frame_valid[g].
//   - axi_rframe_valid = (state==READ) & ch_frame_valid[g].
//   - ch_frame_ready[g] = grant[g] & ((WRITE & axi_wframe_ready) | (READ & axi_rframe_ready)).
//   - Non-granted ready bits are 0.
// CONFIGURATION
//  MC_ARB_RR_EN defined: round-robin arbitration.
//   - Search starts at channel (last_grant+1) mod NUM_CH; the pointer updates on each grant.
//  MC_ARB_RR_EN undefined: fixed priority, lowest valid index wins; no pointer register.
// TESTING
//  T1 NUM_CH=2, start=5, period=9, no traffic -> refresh_start_o pulses; finish after 3 cycles
//     -> state 3->0; repeats every 10 cycles.
//  T2 ch0 and ch1 valid with writes, RR on -> grants alternate 01,10,01.
//     With RR off -> ch0 granted each time.
//  T3 read in flight, 3 rf_due before read_finish_i -> rf_pend=3; then 3 REFRESH passes back to back
//     with one IDLE cycle between.
//  T4 MAX_PEND_RF=2, period=3, refresh_finish_i withheld -> rf_pend stays 2, rf_overflow_o=1
//     and stays set after the refresh completes.
//  T5 mc_en dropped during WRITE -> write completes on write_finish_i, FSM stays IDLE,
//     rf_cnt=0, rf_pend unchanged.
//  T6 rstn low for 1 cycle mid-READ -> next cycle state=0, grant=0, all valid/ready/start outputs 0.

Source files
------------

// File: rtl/mc_arb_fsm.sv
// mc_arb_fsm: front-end arbiter and sequencer for the memory controller.
// Arbitrates NUM_CH frame sources and routes the granted frame to the read
// or write engine. A refresh timer raises refresh requests, which are queued
// in a postponement counter and served between transactions.
// Optional feature macro: MC_ARB_RR_EN selects round-robin arbitration.
// When the macro is not defined, the arbiter uses fixed priority and the
// lowest valid index wins.
module mc_arb_fsm #(
  parameter int NUM_CH      = 2,
  parameter int FRAME_WIDTH = 87,
  parameter int CMD_BIT     = 84,
  parameter int CNT_WIDTH   = 28,
  parameter int MAX_PEND_RF = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          mc_en,
  input  logic [CNT_WIDTH-1:0]          mc_rf_start_time_cfg,
  input  logic [CNT_WIDTH-1:0]          mc_rf_period_time_cfg,
  input  logic [NUM_CH*FRAME_WIDTH-1:0] ch_frame_data,
  input  logic [NUM_CH-1:0]             ch_frame_valid,
  output logic [NUM_CH-1:0]             ch_frame_ready,
  output logic [FRAME_WIDTH-1:0]        axi_wframe_data,
  output logic                          axi_wframe_valid,
  input  logic                          axi_wframe_ready,
  input  logic                          write_finish_i,
  output logic [FRAME_WIDTH-1:0]        axi_rframe_data,
  output logic                          axi_rframe_valid,
  input  logic                          axi_rframe_ready,
  input  logic                          read_finish_i,
  output logic                          refresh_start_o,
  input  logic                          refresh_finish_i,
  output logic [NUM_CH-1:0]             grant_o,
  output logic [1:0]                    curr_state_o,
  output logic                          rf_overflow_o
);

  localparam int PEND_W = $clog2(MAX_PEND_RF + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND_RF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      grant_q, grant_d;
  logic [CNT_WIDTH-1:0]   rf_cnt_q, rf_cnt_d;
  logic [PEND_W-1:0]      rf_pend_q, rf_pend_d;
  logic                   rf_ovf_q, rf_ovf_d;
  logic                   rf_start_q, rf_start_d;

  logic                   rf_due;
  logic                   rf_dec;
  logic [NUM_CH-1:0]      pick_oh;
  logic                   pick_any;
  logic                   pick_cmd;
  logic [FRAME_WIDTH-1:0] frame_sel;
  logic                   grant_valid;

`ifdef MC_ARB_RR_EN
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // The pointer holds the channel where the next search begins, i.e. the
  // channel after the last grant; it starts at channel 0 after reset.
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] rr_next;

  // Round-robin pick: first valid channel at or after the pointer, wrapping.
  always_comb begin
    pick_oh  = '0;
    pick_any = 1'b0;
    rr_next  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!pick_any && ch_frame_valid[i] &&
            (((int'(rr_ptr_q) + k) % NUM_CH) == i)) begin
          pick_any   = 1'b1;
          pick_oh[i] = 1'b1;
          rr_next    = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // Pointer register advances only when a channel is granted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed-priority pick: lowest-index valid channel wins.
  always_comb begin
    pick_oh  = '0;
    pick_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_any && ch_frame_valid[i]) begin
        pick_any   = 1'b1;
        pick_oh[i] = 1'b1;
      end
    end
  end
`endif

  // Command bit of the frame offered by the picked channel decides read vs write.
  always_comb begin
    pick_cmd = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pick_cmd = pick_cmd | (pick_oh[i] & ch_frame_data[i*FRAME_WIDTH + CMD_BIT]);
    end
  end

  // Frame mux driven by the registered grant; all zero when nobody owns the bus.
  always_comb begin
    frame_sel   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      frame_sel   = frame_sel | ({FRAME_WIDTH{grant_q[i]}} &
                                 ch_frame_data[i*FRAME_WIDTH +: FRAME_WIDTH]);
      grant_valid = grant_valid | (grant_q[i] & ch_frame_valid[i]);
    end
  end

  // Refresh timer and postponed-refresh bookkeeping.
  always_comb begin
    rf_due    = mc_en & (rf_cnt_q == mc_rf_start_time_cfg);
    rf_dec    = (state_q == ST_REFRESH) & refresh_finish_i;
    rf_cnt_d  = '0;
    rf_pend_d = rf_pend_q;
    rf_ovf_d  = rf_ovf_q | (rf_due & (rf_pend_q == PEND_MAX));
    if (mc_en && (rf_cnt_q != mc_rf_period_time_cfg)) begin
      rf_cnt_d = rf_cnt_q + CNT_WIDTH'(1);
    end
    // A new request and a completion in the same cycle cancel each other.
    if (rf_due && !rf_dec) begin
      if (rf_pend_q != PEND_MAX) begin
        rf_pend_d = rf_pend_q + PEND_W'(1);
      end
    end else if (rf_dec && !rf_due) begin
      if (rf_pend_q != '0) begin
        rf_pend_d = rf_pend_q - PEND_W'(1);
      end
    end
  end

  // Next-state logic: refresh has priority in IDLE; transactions run to their finish pulse.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rf_start_d = 1'b0;
`ifdef MC_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mc_en) begin
          if (rf_pend_q != '0) begin
            state_d = ST_REFRESH;
          end else if (pick_any) begin
            grant_d = pick_oh;
            state_d = pick_cmd ? ST_WRITE : ST_READ;
`ifdef MC_ARB_RR_EN
            rr_ptr_d = rr_next;
`endif
          end
        end
      end
      ST_READ: begin
        if (read_finish_i) begin
          grant_d = '0;
          state_d = ((rf_pend_q != '0) || rf_due) ? ST_REFRESH : ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (write_finish_i) begin
          grant_d = '0;
          state_d = ((rf_pend_q != '0) || rf_due) ? ST_REFRESH : ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (refresh_finish_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    // Start pulse lands on the first REFRESH cycle only.
    rf_start_d = (state_d == ST_REFRESH) && (state_q != ST_REFRESH);
  end

  // State, grant and refresh registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rf_cnt_q   <= '0;
      rf_pend_q  <= '0;
      rf_ovf_q   <= 1'b0;
      rf_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rf_cnt_q   <= rf_cnt_d;
      rf_pend_q  <= rf_pend_d;
      rf_ovf_q   <= rf_ovf_d;
      rf_start_q <= rf_start_d;
    end
  end

  // Outputs; every output is forced low while rstn is asserted.
  always_comb begin
    axi_wframe_data  = rstn ? frame_sel : '0;
    axi_rframe_data  = rstn ? frame_sel : '0;
    axi_wframe_valid = rstn & (state_q == ST_WRITE) & grant_valid;
    axi_rframe_valid = rstn & (state_q == ST_READ) & grant_valid;
    ch_frame_ready   = '0;
    if (rstn && (((state_q == ST_WRITE) && axi_wframe_ready) ||
                 ((state_q == ST_READ) && axi_rframe_ready))) begin
      ch_frame_ready = grant_q;
    end
    grant_o          = rstn ? grant_q : '0;
    curr_state_o     = rstn ? 2'(state_q) : 2'b00;
    refresh_start_o  = rstn & rf_start_q;
    rf_overflow_o    = rstn & rf_ovf_q;
  end

endmodule

// File: tb/tb_mc_arb_fsm.sv
// Randomized scoreboard bench for mc_arb_fsm with a behavioural reference model.
module tb_mc_arb_fsm;
  localparam int NCH  = 3;
  localparam int FW   = 16;
  localparam int CMDB = 12;
  localparam int CW   = 8;
  localparam int MAXP = 2;
  localparam int NCYC = 3000;

  logic                clk = 1'b0;
  logic                rstn;
  logic                mc_en;
  logic [CW-1:0]       start_cfg, period_cfg;
  logic [NCH*FW-1:0]   ch_frame_data;
  logic [NCH-1:0]      ch_frame_valid;
  logic [NCH-1:0]      ch_frame_ready;
  logic [FW-1:0]       axi_wframe_data, axi_rframe_data;
  logic                axi_wframe_valid, axi_rframe_valid;
  logic                axi_wframe_ready, axi_rframe_ready;
  logic                write_finish_i, read_finish_i, refresh_finish_i;
  logic                refresh_start_o;
  logic [NCH-1:0]      grant_o;
  logic [1:0]          curr_state_o;
  logic                rf_overflow_o;

  always #5 clk = ~clk;

  mc_arb_fsm #(
    .NUM_CH(NCH), .FRAME_WIDTH(FW), .CMD_BIT(CMDB), .CNT_WIDTH(CW), .MAX_PEND_RF(MAXP)
  ) dut (
    .clk(clk), .rstn(rstn), .mc_en(mc_en),
    .mc_rf_start_time_cfg(start_cfg), .mc_rf_period_time_cfg(period_cfg),
    .ch_frame_data(ch_frame_data), .ch_frame_valid(ch_frame_valid),
    .ch_frame_ready(ch_frame_ready),
    .axi_wframe_data(axi_wframe_data), .axi_wframe_valid(axi_wframe_valid),
    .axi_wframe_ready(axi_wframe_ready), .write_finish_i(write_finish_i),
    .axi_rframe_data(axi_rframe_data), .axi_rframe_valid(axi_rframe_valid),
    .axi_rframe_ready(axi_rframe_ready), .read_finish_i(read_finish_i),
    .refresh_start_o(refresh_start_o), .refresh_finish_i(refresh_finish_i),
    .grant_o(grant_o), .curr_state_o(curr_state_o), .rf_overflow_o(rf_overflow_o)
  );

  typedef struct {
    logic [1:0]     st;
    logic [NCH-1:0] gr;
    logic           wv;
    logic           rv;
    logic [NCH-1:0] rdy;
    logic [FW-1:0]  data;
    logic           rs;
    logic           ovf;
  } snap_t;

  typedef struct {
    logic          is_wr;
    logic [FW-1:0] data;
  } hs_t;

  snap_t exp_q[$];
  hs_t   hs_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  // Reference model: 0 idle, 1 read, 2 write, 3 refresh; owner -1 means none.
  int m_st  = 0;
  int m_g   = -1;
  int m_cnt = 0;
  int m_pend = 0;
  int m_ptr = 0;
  bit m_ovf = 1'b0;
  bit m_rs  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick_channel();
    for (int k = 0; k < NCH; k++) begin
`ifdef MC_ARB_RR_EN
      int i = (m_ptr + k) % NCH;
`else
      int i = k;
`endif
      if (ch_frame_valid[i]) return i;
    end
    return -1;
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance the model one clock.
  task automatic cycle_step();
    snap_t s;
    hs_t   h;
    int    nst;
    int    pk;
    bit    due, dec;
    s.st = 2'b00; s.gr = '0; s.wv = 1'b0; s.rv = 1'b0;
    s.rdy = '0; s.data = '0; s.rs = 1'b0; s.ovf = 1'b0;
    if (rstn) begin
      s.st  = 2'(m_st);
      if (m_g >= 0) begin
        s.gr   = NCH'(1 << m_g);
        s.data = ch_frame_data[m_g*FW +: FW];
        s.wv   = (m_st == 2) && ch_frame_valid[m_g];
        s.rv   = (m_st == 1) && ch_frame_valid[m_g];
        if ((m_st == 2 && axi_wframe_ready) || (m_st == 1 && axi_rframe_ready)) s.rdy = s.gr;
      end
      s.rs  = m_rs;
      s.ovf = m_ovf;
    end
    exp_q.push_back(s);
    if (s.wv && axi_wframe_ready) begin h.is_wr = 1'b1; h.data = s.data; hs_q.push_back(h); end
    if (s.rv && axi_rframe_ready) begin h.is_wr = 1'b0; h.data = s.data; hs_q.push_back(h); end

    if (!rstn) begin
      m_st = 0; m_g = -1; m_cnt = 0; m_pend = 0; m_ptr = 0; m_ovf = 1'b0; m_rs = 1'b0;
      return;
    end
    due = mc_en && (m_cnt == int'(start_cfg));
    dec = (m_st == 3) && refresh_finish_i;
    if (due && m_pend == MAXP) m_ovf = 1'b1;
    nst = m_st;
    case (m_st)
      0: if (mc_en) begin
           if (m_pend > 0) nst = 3;
           else begin
             pk = pick_channel();
             if (pk >= 0) begin
               m_g   = pk;
               nst   = ch_frame_data[pk*FW + CMDB] ? 2 : 1;
               m_ptr = (pk + 1) % NCH;
             end
           end
         end
      1: if (read_finish_i)  begin m_g = -1; nst = (m_pend > 0 || due) ? 3 : 0; end
      2: if (write_finish_i) begin m_g = -1; nst = (m_pend > 0 || due) ? 3 : 0; end
      default: if (refresh_finish_i) nst = 0;
    endcase
    if (due && !dec) m_pend = (m_pend < MAXP) ? m_pend + 1 : MAXP;
    else if (dec && !due && m_pend > 0) m_pend = m_pend - 1;
    if (!mc_en) m_cnt = 0;
    else if (m_cnt == int'(period_cfg)) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (1 << CW);
    m_rs = (nst == 3) && (m_st != 3);
    m_st = nst;
  endtask

  // Stimulus: reset, a quiet refresh-only phase, then randomized traffic.
  initial begin
    int prev_st = -1;
    int in_cyc  = 0;
    int lat     = 0;
    bit did_rst = 1'b0;
    logic [NCH-1:0] v;
    rstn = 1'b0; mc_en = 1'b0; start_cfg = 8'd5; period_cfg = 8'd9;
    ch_frame_data = '0; ch_frame_valid = '0;
    axi_wframe_ready = 1'b0; axi_rframe_ready = 1'b0;
    write_finish_i = 1'b0; read_finish_i = 1'b0; refresh_finish_i = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (m_st != prev_st) begin
        in_cyc  = 0;
        prev_st = m_st;
        if (c < 100)      lat = 3;
        else if (m_st == 3) lat = ($urandom_range(0, 7) == 0) ? 25 : $urandom_range(0, 5);
        else              lat = $urandom_range(0, 6);
      end
      write_finish_i = 1'b0; read_finish_i = 1'b0; refresh_finish_i = 1'b0;
      if (c < 3) begin
        rstn = 1'b0;
      end else if (c < 100) begin
        rstn = 1'b1; mc_en = 1'b1; ch_frame_valid = '0;
        if (m_st == 3 && in_cyc == lat) refresh_finish_i = 1'b1;
      end else begin
        rstn = 1'b1;
        if (c == 100) begin start_cfg = 8'd3; period_cfg = 8'd7; end
        mc_en = !(((c % 250) >= 200) && ((c % 250) < 220));
        if ((c % 250) == 205) begin
          period_cfg = 8'($urandom_range(4, 20));
          start_cfg  = 8'($urandom_range(0, int'(period_cfg)));
        end
        for (int i = 0; i < NCH; i++) begin
          v[i] = ($urandom_range(0, 99) < 60);
          ch_frame_data[i*FW +: FW] = 16'($urandom);
        end
        ch_frame_valid   = v;
        axi_wframe_ready = ($urandom_range(0, 3) != 0);
        axi_rframe_ready = ($urandom_range(0, 3) != 0);
        if (m_st == 1 && in_cyc == lat) read_finish_i    = 1'b1;
        if (m_st == 2 && in_cyc == lat) write_finish_i   = 1'b1;
        if (m_st == 3 && in_cyc == lat) refresh_finish_i = 1'b1;
        if (m_st != 1 && $urandom_range(0, 15) == 0) read_finish_i    = 1'b1;
        if (m_st != 2 && $urandom_range(0, 15) == 0) write_finish_i   = 1'b1;
        if (m_st != 3 && $urandom_range(0, 15) == 0) refresh_finish_i = 1'b1;
        if (c >= 1500 && !did_rst && m_st == 1) begin
          rstn    = 1'b0;
          did_rst = 1'b1;
        end
      end
      in_cyc++;
      cycle_step();
    end
    @(negedge clk);
    #5;
    done = 1'b1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("handshakes_drained", 64'(hs_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: compare DUT outputs against the queued expectations, away from the clock edge.
  initial begin
    snap_t s;
    hs_t   h;
    while (!done) begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("curr_state", 64'(curr_state_o), 64'(s.st));
        check("grant", 64'(grant_o), 64'(s.gr));
        check("wframe_valid", 64'(axi_wframe_valid), 64'(s.wv));
        check("rframe_valid", 64'(axi_rframe_valid), 64'(s.rv));
        check("frame_ready", 64'(ch_frame_ready), 64'(s.rdy));
        check("wframe_data", 64'(axi_wframe_data), 64'(s.data));
        check("rframe_data", 64'(axi_rframe_data), 64'(s.data));
        check("refresh_start", 64'(refresh_start_o), 64'(s.rs));
        check("rf_overflow", 64'(rf_overflow_o), 64'(s.ovf));
        if ((axi_wframe_valid && axi_wframe_ready) || (axi_rframe_valid && axi_rframe_ready)) begin
          if (hs_q.size() == 0) begin
            check("unexpected_handshake", 64'd1, 64'd0);
          end else begin
            h = hs_q.pop_front();
            check("handshake_is_write", 64'(axi_wframe_valid), 64'(h.is_wr));
            check("handshake_data",
                  64'(axi_wframe_valid ? axi_wframe_data : axi_rframe_data), 64'(h.data));
          end
        end
      end
    end
  end

endmodule
